// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state encoding and channel-select width helper for the SAR scan controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        OUTPUT,
        NEXT
    } sar_state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// sar_bit_engine: one MSB-first successive-approximation conversion.
// Each bit is held for SETTLE_CYCLES settle cycles and then resolved in a single compare cycle.
module sar_bit_engine #(
    parameter int RESOLUTION    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  compare,
    output logic [RESOLUTION-1:0] dac_code,
    output logic [RESOLUTION-1:0] value,
    output logic                  settle_end,
    output logic                  done
);
    localparam int IW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
    localparam logic [RESOLUTION-1:0] MSB = RESOLUTION'(1) << (RESOLUTION - 1);
    logic          active;
    logic          cmp_ph;
    logic [IW-1:0] idx;
    logic [3:0]    cnt;
    assign settle_end = active & ~cmp_ph & (cnt == 4'(SETTLE_CYCLES - 1));
    assign done       = active & cmp_ph & (idx == '0);
    // Code as it stands after the current compare decision.
    always_comb begin
        value      = dac_code;
        value[idx] = compare;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            cmp_ph   <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            dac_code <= '0;
        end else if (start) begin
            active   <= 1'b1;
            cmp_ph   <= (SETTLE_CYCLES == 0);
            idx      <= IW'(RESOLUTION - 1);
            cnt      <= '0;
            dac_code <= MSB;
        end else if (active && !cmp_ph) begin
            cnt    <= settle_end ? '0 : cnt + 4'd1;
            cmp_ph <= settle_end;
        end else if (active) begin
            active   <= (idx != '0);
            cmp_ph   <= (idx != '0) && (SETTLE_CYCLES == 0);
            idx      <= (idx != '0) ? idx - 1'b1 : idx;
            dac_code <= (idx != '0) ? value | (RESOLUTION'(1) << (idx - 1'b1)) : '0;
        end
    end
endmodule

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR ADC scan controller with a ready/valid result hand-off.
// Define SAR_AVG_EN to average 2^AVG_LOG2 back-to-back conversions per channel.
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int AVG_LOG2      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    compare,
    input  logic                    result_ready,
    output logic [RESOLUTION-1:0]   dac_code,
    output logic [ch_w(NUM_CH)-1:0] ch_sel,
    output logic                    sample,
    output logic                    busy,
    output logic [RESOLUTION-1:0]   result,
    output logic [ch_w(NUM_CH)-1:0] result_ch,
    output logic                    result_valid
);
    localparam int CH_W = ch_w(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("AVG_LOG2 out of range");
    end

    sar_state_e            state, nxt;
    logic [RESOLUTION-1:0] value, final_code;
    logic                  settle_end, done, last_pass, has_up;
    logic [CH_W-1:0]       low_ch, next_ch;

    sar_bit_engine #(
        .RESOLUTION    (RESOLUTION),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (state == SAMPLE),
        .compare    (compare),
        .dac_code   (dac_code),
        .value      (value),
        .settle_end (settle_end),
        .done       (done)
    );

    assign sample = (state == SAMPLE);
    assign busy   = (state != IDLE);

    // Lowest enabled channel, and the next enabled one above ch_sel with wrap-around.
    always_comb begin
        low_ch  = '0;
        next_ch = '0;
        has_up  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) low_ch = CH_W'(i);
            if (ch_mask[i] && CH_W'(i) > ch_sel) begin
                next_ch = CH_W'(i);
                has_up  = 1'b1;
            end
        end
        if (!has_up) next_ch = low_ch;
    end

`ifdef SAR_AVG_EN
    localparam int AW = RESOLUTION + AVG_LOG2;
    logic [AW-1:0]     acc, acc_sum;
    logic [AVG_LOG2:0] avg_cnt;
    assign acc_sum    = acc + AW'(value);
    assign last_pass  = (avg_cnt == (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1));
    assign final_code = acc_sum[AVG_LOG2 +: RESOLUTION];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (state == COMPARE && done) begin
            acc     <= last_pass ? '0 : acc_sum;
            avg_cnt <= last_pass ? '0 : avg_cnt + 1'b1;
        end
    end
`else
    assign last_pass  = 1'b1;
    assign final_code = value;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (enable && |ch_mask) ? SAMPLE : IDLE;
            SAMPLE:  nxt = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
            SETTLE:  nxt = settle_end ? COMPARE : SETTLE;
            COMPARE: nxt = done ? (last_pass ? OUTPUT : SAMPLE) : ((SETTLE_CYCLES == 0) ? COMPARE : SETTLE);
            OUTPUT:  nxt = result_ready ? NEXT : OUTPUT;
            NEXT:    nxt = (enable && |ch_mask) ? SAMPLE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ch_sel       <= '0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == SAMPLE) ch_sel <= low_ch;
            if (state == NEXT && nxt == SAMPLE) ch_sel <= next_ch;
            if (state == COMPARE && nxt == OUTPUT) begin
                result       <= final_code;
                result_ch    <= ch_sel;
                result_valid <= 1'b1;
            end
            if (state == OUTPUT && result_ready) result_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed scenarios for sar_scan_ctrl with a behavioural comparator.
// An input code X is modelled as X + 0.5 LSB, so compare = (dac_code <= X).
module tb_sar_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic       compare;
    logic       result_ready = 1'b1;
    logic [7:0] dac_code;
    logic [1:0] ch_sel;
    logic       sample;
    logic       busy;
    logic [7:0] result;
    logic [1:0] result_ch;
    logic       result_valid;

    logic [7:0] ch_codes [0:3];
    logic [7:0] avg_codes [0:3];
    logic       avg_mode = 1'b0;
    int         n_samp = 0;
    int         avg_base = 0;
    logic [7:0] cur_code;
    int         checks = 0;
    int         passed = 0;

    sar_scan_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .compare      (compare),
        .result_ready (result_ready),
        .dac_code     (dac_code),
        .ch_sel       (ch_sel),
        .sample       (sample),
        .busy         (busy),
        .result       (result),
        .result_ch    (result_ch),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sample) n_samp <= n_samp + 1;

    always_comb begin
        cur_code = avg_mode ? avg_codes[2'(n_samp - avg_base - 1)] : ch_codes[ch_sel];
    end
    assign compare = (dac_code <= cur_code);

    task automatic wait_sample();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample && n < 50);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!result_valid && cyc < 300);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (dac_code !== 8'h00) $display("FAIL rst_dac: got %h want 00", dac_code); else passed++;
        checks++; if (ch_sel !== 2'd0) $display("FAIL rst_ch_sel: got %0d want 0", ch_sel); else passed++;
        checks++; if ({sample, busy, result_valid} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {sample, busy, result_valid}); else passed++;
        checks++; if ({result, result_ch} !== 10'd0) $display("FAIL rst_result: got %h want 000", {result, result_ch}); else passed++;
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
        ch_mask = 4'b0000;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL empty_mask_idle: busy got %b want 0", busy); else passed++;
        enable = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        ch_codes[0] = 8'hA5;
        ch_mask = 4'b0001;
        enable = 1'b1;
        result_ready = 1'b1;
        wait_sample();
        checks++; if ({sample, busy} !== 2'b11) $display("FAIL single_sample: got %b want 11", {sample, busy}); else passed++;
        @(negedge clk);
        checks++; if (dac_code !== 8'h80) $display("FAIL single_trial: got %h want 80", dac_code); else passed++;
        checks++; if (sample !== 1'b0) $display("FAIL single_sample_low: got %b want 0", sample); else passed++;
        wait_valid(cyc);
        checks++; if (cyc !== 16) $display("FAIL single_latency: got %0d want 17", cyc + 1); else passed++;
        checks++; if (result !== 8'hA5) $display("FAIL single_result: got %h want a5", result); else passed++;
        checks++; if (result_ch !== 2'd0) $display("FAIL single_ch: got %0d want 0", result_ch); else passed++;
        checks++; if (dac_code !== 8'h00) $display("FAIL single_dac_output: got %h want 00", dac_code); else passed++;
        enable = 1'b0;
        @(negedge clk);
        checks++; if ({busy, result_valid} !== 2'b10) $display("FAIL single_next: got %b want 10", {busy, result_valid}); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_alternate();
        int         cyc;
        logic [1:0] exp_ch [0:3];
        logic [7:0] exp_val [0:3];
        exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
        exp_val = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        ch_codes[0] = 8'h11;
        ch_codes[1] = 8'h00;
        ch_codes[2] = 8'h22;
        ch_codes[3] = 8'hFF;
        ch_mask = 4'b1010;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_sample();
            checks++; if (ch_sel !== exp_ch[k]) $display("FAIL alt_sel%0d: got %0d want %0d", k, ch_sel, exp_ch[k]); else passed++;
            wait_valid(cyc);
            if (k == 3) enable = 1'b0;
            checks++; if ({result_ch, result} !== {exp_ch[k], exp_val[k]}) $display("FAIL alt_result%0d: got ch%0d %h want ch%0d %h", k, result_ch, result, exp_ch[k], exp_val[k]); else passed++;
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL alt_idle: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        ch_codes[0] = 8'h3C;
        ch_mask = 4'b0001;
        enable = 1'b1;
        result_ready = 1'b0;
        wait_sample();
        wait_valid(cyc);
        checks++; if ({result_ch, result} !== {2'd0, 8'h3C}) $display("FAIL bp_first: got ch%0d %h want ch0 3c", result_ch, result); else passed++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (result !== 8'h3C || result_ch !== 2'd0 || result_valid !== 1'b1 || sample !== 1'b0 || dac_code !== 8'h00) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else passed++;
        result_ready = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) $display("FAIL bp_accept: valid got %b want 0", result_valid); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL bp_idle: busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        ch_codes[1] = 8'h5A;
        ch_codes[2] = 8'h33;
        ch_mask = 4'b0110;
        enable = 1'b1;
        result_ready = 1'b1;
        wait_sample();
        wait_valid(cyc);
        checks++; if ({result_ch, result} !== {2'd1, 8'h5A}) $display("FAIL rm_first: got ch%0d %h want ch1 5a", result_ch, result); else passed++;
        wait_sample();
        checks++; if (ch_sel !== 2'd2) $display("FAIL rm_second_sel: got %0d want 2", ch_sel); else passed++;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", busy); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if ({dac_code, ch_sel, result, result_ch} !== 20'd0) $display("FAIL rm_async_clear: got %h want 00000", {dac_code, ch_sel, result, result_ch}); else passed++;
        checks++; if ({sample, busy, result_valid} !== 3'b000) $display("FAIL rm_async_flags: got %b want 000", {sample, busy, result_valid}); else passed++;
        @(negedge clk);
        reset = 1'b1;
        wait_sample();
        checks++; if (ch_sel !== 2'd1) $display("FAIL rm_restart_sel: got %0d want 1", ch_sel); else passed++;
        wait_valid(cyc);
        enable = 1'b0;
        checks++; if ({result_ch, result} !== {2'd1, 8'h5A}) $display("FAIL rm_restart_result: got ch%0d %h want ch1 5a", result_ch, result); else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int cyc;
        int bad = 0;
        ch_codes[2] = 8'h77;
        ch_mask = 4'b0100;
        enable = 1'b1;
        wait_sample();
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_valid(cyc);
        checks++; if ({result_ch, result} !== {2'd2, 8'h77}) $display("FAIL ed_result: got ch%0d %h want ch2 77", result_ch, result); else passed++;
        checks++; if (cyc !== 13) $display("FAIL ed_latency: got %0d want 13", cyc); else passed++;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (busy !== 1'b0 || sample !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL ed_idle: got %0d busy cycles want 0", bad); else passed++;
    endtask

`ifdef SAR_AVG_EN
    task automatic test_avg();
        int cyc;
        int pulses = 0;
        avg_codes = '{8'h10, 8'h11, 8'h11, 8'h12};
        avg_base = n_samp;
        avg_mode = 1'b1;
        ch_mask = 4'b0001;
        enable = 1'b1;
        wait_sample();
        cyc = 0;
        while (!result_valid && cyc < 300) begin
            if (sample) pulses++;
            @(negedge clk);
            cyc++;
        end
        enable = 1'b0;
        checks++; if (pulses !== 4) $display("FAIL avg_pulses: got %0d want 4", pulses); else passed++;
        checks++; if (cyc !== 68) $display("FAIL avg_latency: got %0d want 68", cyc); else passed++;
        checks++; if (result !== 8'h11) $display("FAIL avg_result: got %h want 11", result); else passed++;
        repeat (2) @(negedge clk);
        avg_mode = 1'b0;
    endtask
`endif

    initial begin
        ch_codes = '{8'h00, 8'h00, 8'h00, 8'h00};
        avg_codes = '{8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
`ifdef SAR_AVG_EN
        test_avg();
`else
        test_single();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_enable_drop();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
